usbphy_apb_cfg_master: RTL
==========================

# usbphy_apb_cfg_master

APB initiator that drives the USB PHY's 32-bit APB configuration port from a simple command/response stream. It sits between the SoC-side PHY management logic (firmware-visible CSRs or a boot-time init sequencer) and the PHY's `psel/penable/pwrite/paddr/pwdata/prdata/pready` pins. It issues one APB transfer per accepted command, waits for `pready`, and returns read data or a timeout error. A bounded wait prevents a hung PHY from stalling the management path.

## Interface
- `TIMEOUT_CYCLES`, default 256: maximum ACCESS-phase cycles waiting for `pready`; 0 disables the timeout.
- `pclk`  in  1  single clock for command side and APB side.
- `reset`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command.
- `cmd_write`  in  1  1 = APB write, 0 = APB read.
- `cmd_addr`  in  32  APB address.
- `cmd_wdata`  in  32  write data; ignored for reads.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  consumer takes the response.
- `rsp_rdata`  out  32  read data; 0 for writes and on error.
- `rsp_err`  out  1  transfer aborted by timeout.
- `psel`, `penable`, `pwrite`  out  1 each  APB control to PHY.
- `paddr`, `pwdata`  out  32 each  APB address and write data.
- `prdata`  in  32  APB read data from PHY.
- `pready`  in  1  APB ready from PHY.

## Operation
- FSM states are IDLE, SETUP, ACCESS and RESP.
- **IDLE:**
  - `cmd_ready`=1.
  - On `cmd_valid & cmd_ready`, register `cmd_write/cmd_addr/cmd_wdata` into `pwrite/paddr/pwdata` and go to SETUP.
- **SETUP:** `psel`=1, `penable`=0, `cmd_ready`=0. Unconditionally go to ACCESS.
- **ACCESS:**
  - `psel`=1, `penable`=1, and `pready` is sampled every cycle.
  - On `pready`=1: capture `prdata` into `rsp_rdata` for reads (0 for writes), clear `rsp_err`, and go to RESP.
  - On timeout: `rsp_err`=1, `rsp_rdata`=0, go to RESP.
- **RESP:**
  - `psel`=`penable`=0, `rsp_valid`=1.
  - Hold `rsp_*` stable until `rsp_valid & rsp_ready`, then go to IDLE.
- `paddr/pwdata/pwrite` hold their values from SETUP through the end of ACCESS.
- `paddr/pwdata/pwrite` may keep their last values while idle; `psel`=0 qualifies them.
- `pready` is ignored outside ACCESS. `prdata` is ignored on writes and outside the `pready` cycle.
- **Timeout counter:**
  - Width is `$clog2(TIMEOUT_CYCLES+1)`. It is cleared on entry to ACCESS and increments each ACCESS cycle with `pready`=0.
  - Timeout fires when the count reaches `TIMEOUT_CYCLES-1` with `pready`=0. This means exactly `TIMEOUT_CYCLES` ACCESS cycles have elapsed.
  - If `pready`=1 and the timeout condition occur in the same cycle, `pready` wins (no error).
  - With `TIMEOUT_CYCLES`=0 the block waits forever.
- **Reset:**
  - All registered outputs go to 0 (`psel`, `penable`, `pwrite`, `paddr`, `pwdata`, `rsp_valid`, `rsp_rdata`, `rsp_err`).
  - State goes to IDLE, so `cmd_ready`=1 immediately after reset deasserts.
  - Reset mid-transfer drops `psel/penable` asynchronously. The in-flight command is lost and no response is produced.
- Only one command is outstanding at a time; there is no pipelining.

## Timing
- Command accepted at edge N; SETUP in cycle N+1; ACCESS from N+2.
- With `pready`=1 in the first ACCESS cycle, `rsp_valid` rises in cycle N+3.
- Minimum transfer is 3 cycles from accept to response. Each PHY wait state adds 1 cycle.
- With `rsp_ready` held at 1, the next `cmd_ready` is in cycle N+4. Best-case throughput is one transfer per 4 cycles.
- A timeout response appears `TIMEOUT_CYCLES` cycles after ACCESS entry: `rsp_valid` rises in cycle N+2+`TIMEOUT_CYCLES`.
- All outputs are registered except `cmd_ready`, which is decoded from state.

## Structure
- Shared package `usbphy_cfg_pkg` holds:
  - the FSM state enum (`IDLE`, `SETUP`, `ACCESS`, `RESP`);
  - `APB_AW`=32 and `APB_DW`=32;
  - the default timeout constant.
- Single flat module; no sub-module. The timeout counter is inline.

## Test plan
- Write 0x0000_0010 ← 0xA5A5_0001 with `pready` tied high → `psel` rises at N+1, `penable` at N+2, `rsp_valid` at N+3 with `rsp_err`=0 and `rsp_rdata`=0.
- Read 0x0000_0004 with 3 wait states and `prdata`=0xDEAD_BEEF on the `pready` cycle → `rsp_rdata`=0xDEAD_BEEF, `rsp_valid` at N+6, address stable throughout ACCESS.
- `TIMEOUT_CYCLES`=8, `pready` stuck at 0 → `psel/penable` drop and `rsp_err`=1, `rsp_rdata`=0 at cycle N+10.
- `pready` asserted on exactly the 8th ACCESS cycle with `TIMEOUT_CYCLES`=8 → `rsp_err`=0 and valid data returned.
- Back-to-back commands with `rsp_ready`=0 for 5 cycles → response held stable, `cmd_ready`=0 until the response handshake, `psel`=0 throughout RESP.
- Assert `reset` during ACCESS → `psel`/`penable` go to 0 the same cycle, no `rsp_valid`, and `cmd_ready`=1 after reset release.

Source files
------------

// File: rtl/usbphy_cfg_pkg.sv
// -----------------------------------------------------------------------------
// usbphy_cfg_pkg
// Shared definitions for the USB PHY APB configuration master:
//   - state_t                : master FSM states
//   - APB_AW / APB_DW        : APB address / data widths
//   - DEFAULT_TIMEOUT_CYCLES : default bound on ACCESS-phase wait for pready
// -----------------------------------------------------------------------------
package usbphy_cfg_pkg;

   localparam int APB_AW                 = 32;
   localparam int APB_DW                 = 32;
   localparam int DEFAULT_TIMEOUT_CYCLES = 256;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_t;

endpackage : usbphy_cfg_pkg

// File: rtl/usbphy_apb_cfg_master.sv
// -----------------------------------------------------------------------------
// usbphy_apb_cfg_master
// Turns a command/response stream into single APB transfers on the USB PHY
// configuration port. One command is outstanding at a time. A bounded wait
// on pready keeps a hung PHY from stalling the management path.
//
// Handshakes: a transfer happens on a cycle where valid and ready are both 1
// at the rising edge of pclk. The producer keeps valid and its payload stable
// until that edge; ready does not depend on valid.
//
// Ports:
//   pclk, reset                     clock, async active-high reset
//   cmd_valid/cmd_ready             command handshake
//   cmd_write, cmd_addr, cmd_wdata  command payload
//   rsp_valid/rsp_ready             response handshake
//   rsp_rdata, rsp_err              response payload (rdata 0 on write/error)
//   psel, penable, pwrite,
//   paddr, pwdata                   APB requester outputs (all registered)
//   prdata, pready                  APB completer inputs
//
// Parameter:
//   TIMEOUT_CYCLES  ACCESS cycles allowed before aborting; 0 waits forever.
// -----------------------------------------------------------------------------
module usbphy_apb_cfg_master
   import usbphy_cfg_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic              pclk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [APB_AW-1:0] cmd_addr,
   input  logic [APB_DW-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [APB_DW-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              psel,
   output logic              penable,
   output logic              pwrite,
   output logic [APB_AW-1:0] paddr,
   output logic [APB_DW-1:0] pwdata,
   input  logic [APB_DW-1:0] prdata,
   input  logic              pready
);

   // A zero timeout still needs a 1-bit counter to keep the declaration legal;
   // the compare below is disabled in that case.
   localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST =
      CW'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q;
   logic            timeout_hit;

   // Count reaches TIMEOUT_CYCLES-1 on the TIMEOUT_CYCLES-th ACCESS cycle.
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

   assign cmd_ready = (state_q == IDLE);

   // -------------------------------------------------------------------------
   // FSM state register
   // -------------------------------------------------------------------------
   always_ff @(posedge pclk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // -------------------------------------------------------------------------
   // FSM next state
   // -------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (cmd_valid)                state_d = SETUP;
         SETUP:                                 state_d = ACCESS;
         ACCESS:  if (pready || timeout_hit)    state_d = RESP;
         RESP:    if (rsp_ready)                state_d = IDLE;
         default:                               state_d = IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // Registered APB and response outputs, timeout counter
   // -------------------------------------------------------------------------
   always_ff @(posedge pclk or posedge reset) begin
      if (reset) begin
         psel      <= 1'b0;
         penable   <= 1'b0;
         pwrite    <= 1'b0;
         paddr     <= '0;
         pwdata    <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         cnt_q     <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (cmd_valid) begin
                  pwrite <= cmd_write;
                  paddr  <= cmd_addr;
                  pwdata <= cmd_wdata;
                  psel   <= 1'b1;
               end
            end
            SETUP: begin
               penable <= 1'b1;
               cnt_q   <= '0;
            end
            ACCESS: begin
               // pready takes priority over a coincident timeout.
               if (pready) begin
                  psel      <= 1'b0;
                  penable   <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b0;
                  rsp_rdata <= pwrite ? '0 : prdata;
               end else if (timeout_hit) begin
                  psel      <= 1'b0;
                  penable   <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                  rsp_rdata <= '0;
               end else if (TIMEOUT_CYCLES != 0) begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            RESP: begin
               if (rsp_ready) rsp_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule : usbphy_apb_cfg_master
